// File: rtl/matrix_skew_feeder.sv
// matrix_skew_feeder
//   Reads one N x N matrix from the K/S matrix buffer on a start command and
//   streams it into the systolic array as 2N-1 diagonally skewed beats under
//   a valid/ready handshake.
//
//   Build option: MATRIX_SKEW_FEEDER_TRANSPOSE_EN
//     defined   -> lane r carries M[t-r][r] (array sees the transpose)
//     undefined -> lane r carries M[r][t-r] (row-major)
//
//   Ports
//     clk, reset_n          clock, asynchronous active-low reset
//     start, sel, base_addr feed request; sel/base_addr latched with start
//     buf_read_en/sel/addr  read request to the matrix buffer
//     buf_matrix            registered buffer output, valid the cycle after read
//     feed_valid/ready      beat handshake toward the array
//     feed_data, feed_last  skewed lane data (lane 0 in the MSBs), final beat
//     busy, done            not-idle flag, one-cycle completion pulse
module matrix_skew_feeder #(
   parameter int INPUT_WIDTH = 8,
   parameter int MATRIX_SIZE = 3,
   parameter int ADDR_WIDTH  = $clog2((MATRIX_SIZE**2) << 2)
) (
   input  logic                                       clk,
   input  logic                                       reset_n,
   input  logic                                       start,
   input  logic                                       sel,
   input  logic [ADDR_WIDTH-1:0]                      base_addr,
   output logic                                       buf_read_en,
   output logic                                       buf_sel,
   output logic [ADDR_WIDTH-1:0]                      buf_addr,
   input  logic [INPUT_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] buf_matrix,
   output logic                                       feed_valid,
   input  logic                                       feed_ready,
   output logic [INPUT_WIDTH*MATRIX_SIZE-1:0]         feed_data,
   output logic                                       feed_last,
   output logic                                       busy,
   output logic                                       done
);

   localparam int N    = MATRIX_SIZE;
   localparam int W    = INPUT_WIDTH;
   localparam int CW   = $clog2(2 * N);              // holds 0 .. 2N-2
   localparam int IW   = (N > 1) ? $clog2(N) : 1;    // row/column index
   localparam int LAST = 2 * N - 2;

   typedef enum logic [2:0] {IDLE, REQ, CAP, FEED, DONE} state_t;

   state_t                         state;
   logic [CW-1:0]                  t;
   logic [N-1:0][N-1:0][W-1:0]     mat;       // mat[row][col]
   logic [N-1:0][N-1:0][W-1:0]     cap_mat;

   // Unpack the buffer word: row 0 / element 0 sit in the most significant bits.
   always_comb begin
      cap_mat = '0;
      for (int i = 0; i < N; i++)
         for (int j = 0; j < N; j++)
            cap_mat[i][j] = buf_matrix[((N - 1 - i) * N + (N - j)) * W - 1 -: W];
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         t        <= '0;
         mat      <= '0;
         buf_sel  <= 1'b0;
         buf_addr <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               buf_sel  <= sel;
               buf_addr <= base_addr;
               state    <= REQ;
            end
            REQ:  state <= CAP;
            CAP: begin
               // buffer output is registered, so the word is valid now
               mat   <= cap_mat;
               t     <= '0;
               state <= FEED;
            end
            FEED: if (feed_ready) begin
               if (t == CW'(LAST)) state <= DONE;
               else                t     <= t + 1'b1;
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // All handshake outputs decode registered state only; feed_ready never
   // reaches them combinationally, so data holds while stalled.
   assign buf_read_en = (state == REQ);
   assign busy        = (state != IDLE);
   assign done        = (state == DONE);
   assign feed_valid  = (state == FEED);
   assign feed_last   = (state == FEED) && (t == CW'(LAST));

   for (genvar r = 0; r < N; r++) begin : g_lane
      logic [W-1:0] lane;
      int           d;   // diagonal offset t-r; lane is live while 0 <= d < N

      always_comb begin
         lane = '0;
         d    = int'(t) - r;
         if (state == FEED && d >= 0 && d < N) begin
`ifdef MATRIX_SKEW_FEEDER_TRANSPOSE_EN
            lane = mat[d[IW-1:0]][r];
`else
            lane = mat[r][d[IW-1:0]];
`endif
         end
      end

      assign feed_data[(N - r) * W - 1 -: W] = lane;
   end

endmodule

// File: tb/tb_matrix_skew_feeder.sv
module tb_matrix_skew_feeder;

   localparam int W  = 8;
   localparam int N  = 3;
   localparam int AW = $clog2((N**2) << 2);

   logic              clk = 1'b0;
   logic              reset_n;
   logic              start;
   logic              sel;
   logic [AW-1:0]     base_addr;
   logic              buf_read_en;
   logic              buf_sel;
   logic [AW-1:0]     buf_addr;
   logic [W*N*N-1:0]  buf_matrix;
   logic              feed_valid;
   logic              feed_ready;
   logic [W*N-1:0]    feed_data;
   logic              feed_last;
   logic              busy;
   logic              done;

   int checks = 0;
   int errors = 0;

   logic [W*N*N-1:0] tb_mat;   // contents the buffer model returns

   matrix_skew_feeder #(.INPUT_WIDTH(W), .MATRIX_SIZE(N), .ADDR_WIDTH(AW)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .sel(sel), .base_addr(base_addr),
      .buf_read_en(buf_read_en), .buf_sel(buf_sel), .buf_addr(buf_addr),
      .buf_matrix(buf_matrix), .feed_valid(feed_valid), .feed_ready(feed_ready),
      .feed_data(feed_data), .feed_last(feed_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Buffer with a registered read port.
   always @(posedge clk or negedge reset_n)
      if (!reset_n)         buf_matrix <= '0;
      else if (buf_read_en) buf_matrix <= tb_mat;

   // Expected beats, lane 0 in the MSBs.
   logic [23:0] exp_a [5];   // rows {1,2,3},{4,5,6},{7,8,9}
   logic [23:0] exp_s [5];   // signed matrix
   initial begin
`ifdef MATRIX_SKEW_FEEDER_TRANSPOSE_EN
      exp_a = '{24'h010000, 24'h040200, 24'h070503, 24'h000806, 24'h000009};
      exp_s = '{24'hFF0000, 24'h7F8000, 24'hFE0100, 24'h000080, 24'h0000FF};
`else
      exp_a = '{24'h010000, 24'h020400, 24'h030507, 24'h000608, 24'h000009};
      exp_s = '{24'hFF0000, 24'h807F00, 24'h0001FE, 24'h008000, 24'h0000FF};
`endif
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_quiet(input string tag);
      chk(tag, {buf_read_en, buf_sel, buf_addr, feed_valid, feed_data, feed_last, busy, done}, '0);
   endtask

   task automatic chk_beat(input string tag, input logic [23:0] d, input logic last);
      chk({tag, "_valid"}, feed_valid, 1'b1);
      chk({tag, "_data"},  feed_data, d);
      chk({tag, "_last"},  feed_last, last);
      chk({tag, "_done"},  done, 1'b0);
   endtask

   initial begin
      reset_n    = 1'b0;
      start      = 1'b0;
      sel        = 1'b0;
      base_addr  = '0;
      feed_ready = 1'b1;
      tb_mat     = '0;
      #3;
      chk_quiet("reset_outputs");
      tick();
      tick();
      reset_n = 1'b1;
      tick();
      chk_quiet("idle_after_reset");

      // ---- Row-major feed with buffer request, sel=1 addr=2 ----
      tb_mat    = 72'h010203040506070809;
      sel       = 1'b1;
      base_addr = 6'd2;
      start     = 1'b1;
      tick();                                   // k+1: REQ
      start     = 1'b0;
      sel       = 1'b0;
      base_addr = 6'd9;
      chk("req_read_en", buf_read_en, 1'b1);
      chk("req_sel",     buf_sel, 1'b1);
      chk("req_addr",    buf_addr, 64'd2);
      chk("req_busy",    busy, 1'b1);
      chk("req_valid",   feed_valid, 1'b0);
      tick();                                   // k+2: CAP
      chk("cap_read_en", buf_read_en, 1'b0);
      chk("cap_valid",   feed_valid, 1'b0);
      chk("cap_data",    feed_data, 64'd0);
      for (int b = 0; b < 5; b++) begin
         tick();                                // k+3 .. k+7
         chk_beat($sformatf("rm_beat%0d", b), exp_a[b], b == 4);
         chk($sformatf("rm_sel%0d", b), {buf_sel, buf_addr}, {1'b1, 6'd2});
      end
      tick();                                   // k+8: DONE
      chk("rm_done",       done, 1'b1);
      chk("rm_done_valid", feed_valid, 1'b0);
      chk("rm_done_data",  feed_data, 64'd0);
      chk("rm_done_busy",  busy, 1'b1);
      tick();
      chk("rm_idle_done",  done, 1'b0);
      chk("rm_idle_busy",  busy, 1'b0);
      chk("rm_hold_sel",   {buf_sel, buf_addr}, {1'b1, 6'd2});

      // ---- Backpressure: two stall cycles on beat t=2 ----
      sel       = 1'b0;
      base_addr = 6'd5;
      start     = 1'b1;
      tick();
      start     = 1'b0;
      chk("bp_read_en", buf_read_en, 1'b1);
      chk("bp_sel",     {buf_sel, buf_addr}, {1'b0, 6'd5});
      tick();
      tick();  chk_beat("bp_beat0", exp_a[0], 1'b0);
      tick();  chk_beat("bp_beat1", exp_a[1], 1'b0);
      tick();  chk_beat("bp_beat2", exp_a[2], 1'b0);
      feed_ready = 1'b0;
      tick();  chk_beat("bp_stall1", exp_a[2], 1'b0);
      tick();  chk_beat("bp_stall2", exp_a[2], 1'b0);
      feed_ready = 1'b1;
      tick();  chk_beat("bp_beat3", exp_a[3], 1'b0);
      tick();  chk_beat("bp_beat4", exp_a[4], 1'b1);
      tick();
      chk("bp_done", done, 1'b1);
      start = 1'b1;                             // start in DONE is dropped
      tick();
      chk("done_start_busy", busy, 1'b0);
      chk("done_start_req",  buf_read_en, 1'b0);
      start = 1'b0;
      tick();
      chk("done_start_idle", busy, 1'b0);

      // ---- Signed pass-through ----
      tb_mat    = 72'hFF80007F0180FE00FF;
      sel       = 1'b1;
      base_addr = 6'd7;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      for (int b = 0; b < 5; b++) begin
         tick();
         chk_beat($sformatf("sg_beat%0d", b), exp_s[b], b == 4);
      end
      tick();
      chk("sg_done", done, 1'b1);
      tick();

      // ---- Ignored start during FEED, then reset mid-feed ----
      tb_mat    = 72'h010203040506070809;
      sel       = 1'b0;
      base_addr = 6'd3;
      start     = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();  chk_beat("rs_beat0", exp_a[0], 1'b0);
      start = 1'b1;
      tick();  chk_beat("rs_beat1", exp_a[1], 1'b0);
      start   = 1'b0;
      reset_n = 1'b0;
      #1;
      chk_quiet("rs_async");
      tick();
      chk_quiet("rs_held");
      reset_n = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         chk($sformatf("rs_after%0d", c), {feed_valid, busy, done, buf_read_en}, 4'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/matrix_skew_feeder.md
# matrix_skew_feeder

Downstream stage of the K/S matrix buffer. On a start command it issues one read to the buffer, captures the returned N×N matrix, and streams it into the systolic array as 2N-1 diagonally skewed beats under a valid/ready handshake. It sits between the buffer's read port and the array's row-lane inputs.

## Interface
- INPUT_WIDTH, 8, bits per signed matrix element
- MATRIX_SIZE, 3, N (matrix is N×N; array has N lanes)
- ADDR_WIDTH, $clog2(MATRIX_SIZE**2 << 2), buffer row-address width

- clk  in  1  clock, all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- start  in  1  request one feed; sampled only in IDLE
- sel  in  1  0 = K matrix, 1 = S matrix; latched with start
- base_addr  in  ADDR_WIDTH  buffer row index of matrix row 0; latched with start
- buf_read_en  out  1  to buffer K_V_read_EN
- buf_sel  out  1  to buffer K_V_sel
- buf_addr  out  ADDR_WIDTH  to buffer K_V_addr
- buf_matrix  in  INPUT_WIDTH*N*N  from buffer MATRIX_OUTPUT; row i at bits [(N-i)*W*N-1 -: W*N], element j of a row at [(N-j)*W-1 -: W] (W = INPUT_WIDTH)
- feed_valid  out  1  beat present
- feed_ready  in  1  array accepts beat
- feed_data  out  INPUT_WIDTH*N  lane r at [(N-r)*W-1 -: W]
- feed_last  out  1  final beat of the feed
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last beat is accepted

## Operation
- States: IDLE, REQ, CAP, FEED, DONE.
- IDLE: outputs idle. On start=1, latch sel and base_addr into buf_sel and buf_addr, then go to REQ.
- REQ: buf_read_en=1 for exactly one cycle, then go to CAP.
- CAP: buf_matrix is valid in this cycle because the buffer registers its output. Copy it into a local N×N register, clear the beat counter t, then go to FEED.
- FEED: feed_valid=1.
  - Lane r carries M[r][t-r] when 0 ≤ t-r < N, otherwise 0.
  - t advances only on feed_valid && feed_ready.
  - feed_last=1 when t = 2N-2. When that beat is accepted, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Elements are signed and pass through bit-exact. There is no arithmetic and no width change.
- start outside IDLE is ignored and not queued. start in the DONE cycle is also ignored.
- buf_sel and buf_addr hold their latched values until the next accepted start.
- feed_valid, feed_data and feed_last are decoded from registered state, counter and local matrix only. There is no combinational path from feed_ready.
- While feed_valid && !feed_ready, feed_data and feed_last are held stable.
- feed_data = 0 outside FEED.
- Reset, including mid-feed, behaves identically:
  - state goes to IDLE; t and the local matrix are zeroed.
  - Every output goes to 0: buf_read_en, buf_sel, buf_addr, feed_valid, feed_data, feed_last, busy, done.
  - A feed interrupted by reset is abandoned and never resumes.

## Timing
- start sampled high at edge k:
  - REQ in cycle k+1.
  - CAP in cycle k+2.
  - First beat valid in cycle k+3, so start-to-first-beat latency is 3 cycles.
- With feed_ready held at 1:
  - Beats occupy cycles k+3 … k+2N+1.
  - done in cycle k+2N+2.
  - busy is high in cycles k+1 … k+2N+2.
  - For N=3: beats in cycles k+3 … k+7, done in k+8.
- Each cycle of feed_ready=0 during FEED delays the remaining beats and done by one cycle.
- Back-to-back operation: the earliest next start is sampled in the cycle after DONE.

## Configuration
- MATRIX_SKEW_FEEDER_TRANSPOSE_EN
  - Defined: lane r carries the column-major element M[t-r][r] (same validity window), so the array sees the transposed matrix.
  - Undefined: row-major M[r][t-r] as described above.
  - Timing, handshake and reset behaviour are identical in both builds.

## Test plan
- Row-major feed.
  - Stimulus: N=3, W=8, feed_ready=1, rows {1,2,3},{4,5,6},{7,8,9}.
  - Required: beats (lane0,lane1,lane2) = (1,0,0),(2,4,0),(3,5,7),(0,6,8),(0,0,9); feed_last only on the 5th beat; done 1 cycle later.
- Transpose build.
  - Stimulus: same as row-major, with MATRIX_SKEW_FEEDER_TRANSPOSE_EN defined.
  - Required: (1,0,0),(4,2,0),(7,5,3),(0,8,6),(0,0,9).
- Buffer request.
  - Stimulus: start with sel=1, base_addr=2.
  - Required: buf_read_en high exactly in cycle k+1; buf_sel=1 and buf_addr=2 from k+1 until the next start.
- Backpressure.
  - Stimulus: drop feed_ready for 2 cycles during beat t=2.
  - Required: beat (3,5,7) held stable, no beat lost or duplicated, done delayed 2 cycles.
- Reset and ignored start.
  - Stimulus: assert reset_n=0 during beat t=1.
  - Required: all outputs 0 immediately; no further beats. A start pulsed during FEED is ignored.
- Signed values.
  - Stimulus: matrix containing -1 and -128.
  - Required: lanes carry 8'hFF and 8'h80 unchanged.
